// File: rtl/spi_tx_arbiter_pkg.sv
// Shared types and default widths for the SPI transmit path.
// The default data width matches the SPI transmitter.
package spi_pkg;

  localparam int SPI_DATA_WIDTH = 8;
  localparam int SPI_NUM_REQ    = 4;

  typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_GAP} arb_state_t;

endpackage

// File: rtl/spi_tx_arbiter_if.sv
// Requester/transmitter bus of the SPI transmit arbiter.
// master = sources plus transmitter side, slave = arbiter.
interface spi_tx_arbiter_if
  import spi_pkg::*;
#(
  parameter int P_DATA_WIDTH = SPI_DATA_WIDTH,
  parameter int P_NUM_REQ    = SPI_NUM_REQ
);

  localparam int SW = $clog2(P_NUM_REQ);

  logic [P_NUM_REQ-1:0]              req_valid;
  logic [P_NUM_REQ*P_DATA_WIDTH-1:0] req_data;
  logic [P_NUM_REQ-1:0]              req_ready;
  logic                              tx_valid;
  logic [P_DATA_WIDTH-1:0]           tx_data;
  logic                              tx_ready;
  logic [SW-1:0]                     tx_sel;

  modport master (
    output req_valid, req_data, tx_ready,
    input  req_ready, tx_valid, tx_data, tx_sel
  );

  modport slave (
    input  req_valid, req_data, tx_ready,
    output req_ready, tx_valid, tx_data, tx_sel
  );

endinterface

// File: rtl/spi_tx_arbiter_rr_pick.sv
// Combinational round-robin find-first: lowest index at or above i_ptr
// (with wrap) whose request bit is set.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [IW-1:0] o_idx,
  output logic          o_found
);

  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!o_found && i_req[(int'(i_ptr) + k) % N]) begin
        o_idx   = IW'((int'(i_ptr) + k) % N);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_tx_arbiter.sv
// Round-robin arbiter sharing one SPI transmitter among P_NUM_REQ sources,
// with bounded bursts and a chip-select gap between bursts.
module spi_tx_arbiter
  import spi_pkg::*;
#(
  parameter int P_DATA_WIDTH = SPI_DATA_WIDTH,
  parameter int P_NUM_REQ    = SPI_NUM_REQ,
  parameter int P_MAX_BURST  = 4,
  parameter int P_GAP_CYCLES = 2
) (
  input  logic             clk_100,
  input  logic             a_rst,
  input  logic             s_rst,
  input  logic             enable,
  spi_tx_arbiter_if.slave  bus,
  output logic             busy
);

  localparam int IW = $clog2(P_NUM_REQ);
  localparam int BW = $clog2(P_MAX_BURST + 1);
  localparam int GW = (P_GAP_CYCLES > 0) ? $clog2(P_GAP_CYCLES + 1) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(P_MAX_BURST - 1);
  localparam logic [BW-1:0] BEAT_MAX  = BW'(P_MAX_BURST);
  // GAP exits on the cycle the counter reads zero, so load one less.
  localparam logic [GW-1:0] GAP_LOAD  = (P_GAP_CYCLES > 0) ? GW'(P_GAP_CYCLES - 1) : '0;

  arb_state_t    r_state, w_state_nxt;
  logic [IW-1:0] r_grant, r_rr_ptr, w_pick_idx;
  logic [BW-1:0] r_beat_cnt;
  logic [GW-1:0] r_gap_cnt;
  logic          w_pick_found, w_gvalid, w_start, w_beat, w_burst_end;

  rr_pick #(.N(P_NUM_REQ), .IW(IW)) u_pick (
    .i_req   (bus.req_valid),
    .i_ptr   (r_rr_ptr),
    .o_idx   (w_pick_idx),
    .o_found (w_pick_found)
  );

  assign w_gvalid    = bus.req_valid[r_grant];
  assign w_start     = enable & w_pick_found;
  assign w_beat      = (r_state == ST_XFER) & w_gvalid & bus.tx_ready;
  assign w_burst_end = (r_state == ST_XFER) &
                       ((w_beat & (r_beat_cnt == LAST_BEAT)) | ~w_gvalid);

  always_ff @(posedge clk_100 or posedge a_rst) begin
    if (a_rst)      r_state <= ST_IDLE;
    else if (s_rst) r_state <= ST_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_start) w_state_nxt = ST_XFER;
      ST_XFER: if (w_burst_end) w_state_nxt = (P_GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
      ST_GAP:  if (r_gap_cnt == '0) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_100 or posedge a_rst) begin
    if (a_rst || s_rst) begin
      r_grant    <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
      r_gap_cnt  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_grant    <= w_pick_idx;
            r_beat_cnt <= '0;
          end
        end
        ST_XFER: begin
          if (w_beat && r_beat_cnt != BEAT_MAX) r_beat_cnt <= r_beat_cnt + 1'b1;
          if (w_burst_end) begin
            r_rr_ptr  <= (r_grant == IW'(P_NUM_REQ - 1)) ? '0 : r_grant + 1'b1;
            r_gap_cnt <= GAP_LOAD;
          end
        end
        ST_GAP: begin
          if (r_gap_cnt != '0) r_gap_cnt <= r_gap_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Granted requester is wired straight through; no added latency.
  always_comb begin
    bus.tx_valid  = 1'b0;
    bus.tx_data   = '0;
    bus.req_ready = '0;
    if (r_state == ST_XFER) begin
      bus.tx_valid           = w_gvalid;
      bus.tx_data            = bus.req_data[r_grant*P_DATA_WIDTH +: P_DATA_WIDTH];
      bus.req_ready[r_grant] = bus.tx_ready;
    end
  end

  assign bus.tx_sel = r_grant;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Directed bench for spi_tx_arbiter: 4 requesters, burst 4, gap 2.
module tb_spi_tx_arbiter;

  logic       clk_100 = 1'b0;
  logic       a_rst, s_rst, enable, busy;
  logic [7:0] word [4];
  int         vectors     = 0;
  int         miscompares = 0;

  always #5 clk_100 = ~clk_100;

  spi_tx_arbiter_if #(.P_DATA_WIDTH(8), .P_NUM_REQ(4)) bus ();

  assign bus.req_data = {word[3], word[2], word[1], word[0]};

  spi_tx_arbiter #(
    .P_DATA_WIDTH (8),
    .P_NUM_REQ    (4),
    .P_MAX_BURST  (4),
    .P_GAP_CYCLES (2)
  ) dut (
    .clk_100 (clk_100),
    .a_rst   (a_rst),
    .s_rst   (s_rst),
    .enable  (enable),
    .bus     (bus),
    .busy    (busy)
  );

  task automatic chk(input string tag, input logic v, input logic [7:0] d,
                     input logic [1:0] sel, input logic b, input logic [3:0] rdy);
    logic [15:0] got, exp;
    got = {bus.tx_valid, bus.tx_data, bus.tx_sel, busy, bus.req_ready};
    exp = {v, d, sel, b, rdy};
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got v=%b d=%h sel=%0d busy=%b rdy=%b, expected v=%b d=%h sel=%0d busy=%b rdy=%b",
             tag, got[15], got[14:7], got[6:5], got[4], got[3:0], v, d, sel, b, rdy);
    end
  endtask

  // Check the current cycle, clock it, and advance the source whose word was accepted.
  task automatic cyc(input string tag, input logic v, input logic [7:0] d,
                     input logic [1:0] sel, input logic b, input logic [3:0] rdy);
    #1;
    chk(tag, v, d, sel, b, rdy);
    @(posedge clk_100);
    #1;
    if (v && rdy != 4'b0000) word[sel] = word[sel] + 8'h01;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] g;
    a_rst = 1'b1; s_rst = 1'b0; enable = 1'b0;
    bus.req_valid = 4'b1111; bus.tx_ready = 1'b1;
    word[0] = 8'h01; word[1] = 8'h21; word[2] = 8'h11; word[3] = 8'h61;
    #2 chk("reset", 1'b0, 8'h00, 2'd0, 1'b0, 4'b0000);
    @(negedge clk_100);
    a_rst = 1'b0; enable = 1'b1; bus.req_valid = 4'b0100;

    // single requester 2
    cyc("t1_idle",  1'b0, 8'h00, 2'd0, 1'b0, 4'b0000);
    cyc("t1_b0",    1'b1, 8'h11, 2'd2, 1'b1, 4'b0100);
    cyc("t1_b1",    1'b1, 8'h12, 2'd2, 1'b1, 4'b0100);
    cyc("t1_b2",    1'b1, 8'h13, 2'd2, 1'b1, 4'b0100);
    cyc("t1_b3",    1'b1, 8'h14, 2'd2, 1'b1, 4'b0100);
    cyc("t1_gap0",  1'b0, 8'h00, 2'd2, 1'b1, 4'b0000);
    cyc("t1_gap1",  1'b0, 8'h00, 2'd2, 1'b1, 4'b0000);
    cyc("t1_idle2", 1'b0, 8'h00, 2'd2, 1'b0, 4'b0000);
    cyc("t1_re0",   1'b1, 8'h15, 2'd2, 1'b1, 4'b0100);
    bus.req_valid = 4'b0000;
    cyc("t1_drop",  1'b0, 8'h16, 2'd2, 1'b1, 4'b0100);
    cyc("t1_gap2",  1'b0, 8'h00, 2'd2, 1'b1, 4'b0000);
    cyc("t1_gap3",  1'b0, 8'h00, 2'd2, 1'b1, 4'b0000);

    // synchronous reset restarts the pointer before the fairness run
    s_rst = 1'b1;
    cyc("t2_srst_pre", 1'b0, 8'h00, 2'd2, 1'b0, 4'b0000);
    s_rst = 1'b0;
    chk("t2_srst", 1'b0, 8'h00, 2'd0, 1'b0, 4'b0000);

    // all requesters valid: grants 0,1,2,3,0
    word[2] = 8'h41;
    bus.req_valid = 4'b1111;
    cyc("t2_idle", 1'b0, 8'h00, 2'd0, 1'b0, 4'b0000);
    for (int b = 0; b < 5; b++) begin
      g = 2'(b % 4);
      for (int k = 0; k < 4; k++)
        cyc("t2_beat", 1'b1, 8'(8'h01 + 8'h20 * g + k + 4 * (b / 4)), g, 1'b1, 4'(4'b0001 << g));
      cyc("t2_gap0", 1'b0, 8'h00, g, 1'b1, 4'b0000);
      cyc("t2_gap1", 1'b0, 8'h00, g, 1'b1, 4'b0000);
      if (b == 4) bus.req_valid = 4'b0000;
      cyc("t2_idle", 1'b0, 8'h00, g, 1'b0, 4'b0000);
    end

    // requester 1 yields after two beats; next grant goes to 2
    bus.req_valid = 4'b0110;
    cyc("t3_idle",  1'b0, 8'h00, 2'd0, 1'b0, 4'b0000);
    cyc("t3_b0",    1'b1, 8'h25, 2'd1, 1'b1, 4'b0010);
    cyc("t3_b1",    1'b1, 8'h26, 2'd1, 1'b1, 4'b0010);
    bus.req_valid = 4'b0100;
    cyc("t3_drop",  1'b0, 8'h27, 2'd1, 1'b1, 4'b0010);
    bus.req_valid = 4'b0110;
    cyc("t3_gap0",  1'b0, 8'h00, 2'd1, 1'b1, 4'b0000);
    cyc("t3_gap1",  1'b0, 8'h00, 2'd1, 1'b1, 4'b0000);
    cyc("t3_idle2", 1'b0, 8'h00, 2'd1, 1'b0, 4'b0000);
    cyc("t3_g2b0",  1'b1, 8'h45, 2'd2, 1'b1, 4'b0100);
    cyc("t3_g2b1",  1'b1, 8'h46, 2'd2, 1'b1, 4'b0100);
    cyc("t3_g2b2",  1'b1, 8'h47, 2'd2, 1'b1, 4'b0100);
    cyc("t3_g2b3",  1'b1, 8'h48, 2'd2, 1'b1, 4'b0100);
    bus.req_valid = 4'b0010;
    cyc("t3_gap2",  1'b0, 8'h00, 2'd2, 1'b1, 4'b0000);
    cyc("t3_gap3",  1'b0, 8'h00, 2'd2, 1'b1, 4'b0000);
    cyc("t3_idle3", 1'b0, 8'h00, 2'd2, 1'b0, 4'b0000);

    // tx_ready toggling: only accepted cycles count
    bus.tx_ready = 1'b1; cyc("t4_r1a", 1'b1, 8'h27, 2'd1, 1'b1, 4'b0010);
    bus.tx_ready = 1'b0; cyc("t4_r0a", 1'b1, 8'h28, 2'd1, 1'b1, 4'b0000);
    bus.tx_ready = 1'b1; cyc("t4_r1b", 1'b1, 8'h28, 2'd1, 1'b1, 4'b0010);
    bus.tx_ready = 1'b0; cyc("t4_r0b", 1'b1, 8'h29, 2'd1, 1'b1, 4'b0000);
    bus.tx_ready = 1'b1; cyc("t4_r1c", 1'b1, 8'h29, 2'd1, 1'b1, 4'b0010);
    bus.tx_ready = 1'b0; cyc("t4_r0c", 1'b1, 8'h2A, 2'd1, 1'b1, 4'b0000);
    bus.tx_ready = 1'b1; cyc("t4_r1d", 1'b1, 8'h2A, 2'd1, 1'b1, 4'b0010);
    bus.req_valid = 4'b0000;
    cyc("t4_gap0", 1'b0, 8'h00, 2'd1, 1'b1, 4'b0000);
    cyc("t4_gap1", 1'b0, 8'h00, 2'd1, 1'b1, 4'b0000);
    cyc("t4_idle", 1'b0, 8'h00, 2'd1, 1'b0, 4'b0000);

    // async reset mid-burst, then sync reset mid-burst
    bus.req_valid = 4'b1000;
    cyc("t5_idle", 1'b0, 8'h00, 2'd1, 1'b0, 4'b0000);
    cyc("t5_b0",   1'b1, 8'h65, 2'd3, 1'b1, 4'b1000);
    #2 a_rst = 1'b1;
    #1 chk("t5_arst", 1'b0, 8'h00, 2'd0, 1'b0, 4'b0000);
    #1 a_rst = 1'b0;
    bus.req_valid = 4'b1010;
    cyc("t5_idle2", 1'b0, 8'h00, 2'd0, 1'b0, 4'b0000);
    cyc("t5_b0r",   1'b1, 8'h2B, 2'd1, 1'b1, 4'b0010);
    s_rst = 1'b1; bus.tx_ready = 1'b0;
    cyc("t5_srst_pre", 1'b1, 8'h2C, 2'd1, 1'b1, 4'b0000);
    s_rst = 1'b0; bus.tx_ready = 1'b1;
    chk("t5_srst", 1'b0, 8'h00, 2'd0, 1'b0, 4'b0000);
    cyc("t5_idle3", 1'b0, 8'h00, 2'd0, 1'b0, 4'b0000);
    cyc("t5_b0s",   1'b1, 8'h2C, 2'd1, 1'b1, 4'b0010);
    bus.req_valid = 4'b0000;
    cyc("t5_drop",  1'b0, 8'h2D, 2'd1, 1'b1, 4'b0010);
    cyc("t5_gap0",  1'b0, 8'h00, 2'd1, 1'b1, 4'b0000);
    cyc("t5_gap1",  1'b0, 8'h00, 2'd1, 1'b1, 4'b0000);
    cyc("t5_idle4", 1'b0, 8'h00, 2'd1, 1'b0, 4'b0000);

    // enable gates new grants only
    enable = 1'b0; bus.req_valid = 4'b0001;
    cyc("t6_hold0", 1'b0, 8'h00, 2'd1, 1'b0, 4'b0000);
    cyc("t6_hold1", 1'b0, 8'h00, 2'd1, 1'b0, 4'b0000);
    enable = 1'b1;
    cyc("t6_en",    1'b0, 8'h00, 2'd1, 1'b0, 4'b0000);
    enable = 1'b0;
    cyc("t6_b0",    1'b1, 8'h09, 2'd0, 1'b1, 4'b0001);
    cyc("t6_b1",    1'b1, 8'h0A, 2'd0, 1'b1, 4'b0001);
    cyc("t6_b2",    1'b1, 8'h0B, 2'd0, 1'b1, 4'b0001);
    cyc("t6_b3",    1'b1, 8'h0C, 2'd0, 1'b1, 4'b0001);
    cyc("t6_gap0",  1'b0, 8'h00, 2'd0, 1'b1, 4'b0000);
    cyc("t6_gap1",  1'b0, 8'h00, 2'd0, 1'b1, 4'b0000);
    cyc("t6_idle0", 1'b0, 8'h00, 2'd0, 1'b0, 4'b0000);
    cyc("t6_idle1", 1'b0, 8'h00, 2'd0, 1'b0, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
